lcd_spi_rx: RTL

Write-only 4-wire SPI responder modelling the LCD panel side of the link: SCK, SDA, CS, DC and the panel reset pin. It is driven by the team's LCD init/reset masters.
- Samples the serial lines in the CLK domain and assembles MSB-first bytes tagged with DC.
- Tracks the panel power state (reset, sleep, wake delay, awake) from the hardware reset pin and the SWRESET, SLPIN and SLPOUT commands.
- Used as a loopback target on the Nano board and as the bench model for master blocks.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_spi_shift.sv | 110 +++++++++++
 rtl/lcd_spi_rx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD panel-side SPI responder and the LCD master blocks:
// power states, panel command codes and default delay lengths.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_HW_RST  = 3'd0,
        ST_RECOVER = 3'd1,
        ST_SLEEP   = 3'd2,
        ST_WAKING  = 3'd3,
        ST_AWAKE   = 3'd4
    } power_state_e;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;

    // Delay defaults assume a 36 MHz CLK (WAKE = 120 ms).
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_RESET_CYCLES = 1048576;
    localparam int DEF_WAKE_CYCLES  = 4320000;
    localparam int DEF_CNT_W        = 26;

    function automatic logic is_ready(input power_state_e s);
        return (s == ST_SLEEP) || (s == ST_AWAKE);
    endfunction

endpackage

// File: rtl/lcd_spi_shift.sv
// Serial front end: synchronises SCK/SDA/CS/DC/LCD_RSTN into CLK, detects SCK and CS edges,
// assembles MSB-first bytes and flags bytes cut short by CS.
module lcd_spi_shift #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sda,
    input  logic       cs,
    input  logic       dc,
    input  logic       rstn,
    input  logic       hold,
    output logic       rstn_sync,
    output logic       byte_done,
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       rx_valid,
    output logic       frame_err
);

    logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
    logic [4:0] sync_out;
    logic       sck_s, sda_s, cs_s, dc_s, rstn_s;
    logic       sck_prev_q, sck_prev_d;
    logic       cs_prev_q, cs_prev_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_dc_q, rx_dc_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       hold_all, sck_rise, cs_rise, shift_en, done;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign sck_s    = sync_out[0];
    assign sda_s    = sync_out[1];
    assign cs_s     = sync_out[2];
    assign dc_s     = sync_out[3];
    assign rstn_s   = sync_out[4];

    assign hold_all = hold | ~rstn_s;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    // An SCK edge arriving together with CS rising still belongs to the frame.
    assign shift_en = sck_rise & ~(cs_s & cs_prev_q);
    assign done     = shift_en && (bit_cnt_q == 3'd7);

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], {rstn, dc, cs, sda, sck}};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_dc_d     = rx_dc_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (hold_all) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else begin
            if (shift_en) begin
                shift_d   = {shift_q[6:0], sda_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (done) begin
                rx_valid_d = 1'b1;
                rx_data_d  = {shift_q[6:0], sda_s};
                rx_dc_d    = dc_s;
            end else if (cs_rise && (bit_cnt_q != 3'd0 || shift_en)) begin
                frame_err_d = 1'b1;
                shift_d     = '0;
                bit_cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_dc_q     <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_dc_q     <= rx_dc_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rstn_sync = rstn_s;
    assign byte_done = done & ~hold_all;
    assign rx_data   = rx_data_q;
    assign rx_dc     = rx_dc_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/lcd_spi_rx.sv
// Panel-side 4-wire SPI responder with power-state tracking (reset, sleep, wake, awake).
// Optional LCD_SPI_RX_BYTECNT_EN adds a 16-bit received-byte counter on RX_COUNT.
module lcd_spi_rx
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SCK,
    input  logic        SDA,
    input  logic        CS,
    input  logic        DC,
    input  logic        LCD_RSTN,
    output logic [7:0]  RX_DATA,
    output logic        RX_DC,
    output logic        RX_VALID,
    output logic        FRAME_ERR,
    output logic        CMD_REJECT,
    output logic        AWAKE,
`ifdef LCD_SPI_RX_BYTECNT_EN
    output logic [15:0] RX_COUNT,
`endif
    output logic        LED
);

    localparam logic [CNT_W-1:0] RESET_TERM = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_TERM  = CNT_W'(WAKE_CYCLES - 1);

    power_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_reject_q, cmd_reject_d;
    logic             awake_q, awake_d;
    logic             rstn_s, byte_done, rx_valid, rx_dc, cmd;
    logic [7:0]       rx_data;

    lcd_spi_shift #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_shift (
        .clk      (CLK),
        .reset    (RESET),
        .sck      (SCK),
        .sda      (SDA),
        .cs       (CS),
        .dc       (DC),
        .rstn     (LCD_RSTN),
        .hold     (state_q == ST_HW_RST),
        .rstn_sync(rstn_s),
        .byte_done(byte_done),
        .rx_data  (rx_data),
        .rx_dc    (rx_dc),
        .rx_valid (rx_valid),
        .frame_err(FRAME_ERR)
    );

    // Commands are decoded from the registered byte, so state moves the cycle after RX_VALID.
    assign cmd = rx_valid && !rx_dc;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_reject_d = byte_done && !is_ready(state_q);
        unique case (state_q)
            ST_HW_RST: begin
                if (rstn_s) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == RESET_TERM) begin
                    state_d = ST_SLEEP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SLEEP: begin
                if (cmd && rx_data == CMD_SLPOUT) begin
                    state_d = ST_WAKING;
                    cnt_d   = '0;
                end else if (cmd && rx_data == CMD_SWRESET) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end
            end
            ST_WAKING: begin
                if (cmd && rx_data == CMD_SWRESET) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end else if (cnt_q == WAKE_TERM) begin
                    state_d = ST_AWAKE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_AWAKE: begin
                if (cmd && rx_data == CMD_SLPIN) begin
                    state_d = ST_SLEEP;
                end else if (cmd && rx_data == CMD_SWRESET) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_HW_RST;
                cnt_d   = '0;
            end
        endcase
        // The panel reset pin overrides every state.
        if (!rstn_s) begin
            state_d = ST_HW_RST;
            cnt_d   = '0;
        end
        awake_d = (state_d == ST_AWAKE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_HW_RST;
            cnt_q        <= '0;
            cmd_reject_q <= 1'b0;
            awake_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_reject_q <= cmd_reject_d;
            awake_q      <= awake_d;
        end
    end

`ifdef LCD_SPI_RX_BYTECNT_EN
    logic [15:0] rx_count_q, rx_count_d;

    always_comb begin
        rx_count_d = rx_count_q;
        if (state_q == ST_HW_RST) begin
            rx_count_d = '0;
        end else if (rx_valid) begin
            rx_count_d = rx_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_count_q <= '0;
        end else begin
            rx_count_q <= rx_count_d;
        end
    end

    assign RX_COUNT = rx_count_q;
`endif

    assign RX_DATA    = rx_data;
    assign RX_DC      = rx_dc;
    assign RX_VALID   = rx_valid;
    assign CMD_REJECT = cmd_reject_q;
    assign AWAKE      = awake_q;
    assign LED        = awake_q;

endmodule
